// File: rtl/uart_tx.sv
// uart_tx: 8N1 / 8E1 / 8O1 asynchronous serial transmitter.
// One byte per request: start bit, 8 data bits LSB first, optional parity bit, one stop bit.
// Each bit lasts PRESCALE clock cycles. tx_out and busy are registered outputs.
// Build option: define UART_TX_PARITY_EN to compile in the PARITY state and parity logic;
// without it par_en/par_typ are ignored and every frame is 10 bit-times long.
module uart_tx #(
    parameter int unsigned PRESCALE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] p_data,
    input  logic       data_valid,
    input  logic       par_en,
    input  logic       par_typ,
    output logic       tx_out,
    output logic       busy
);

    // Last cycle index within one serial bit.
    localparam logic [7:0] CntMax = 8'(PRESCALE - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
        StParity = 3'd3,
`endif
        StStop   = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;

    logic       bit_done;
    logic       accept;
    logic       par_bit;

    assign bit_done = (cnt_q == CntMax);
    assign accept   = (state_q == StIdle) && data_valid;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_q, par_d;

    // Capture the frame's parity settings and bit on acceptance; hold them for the frame.
    always_comb begin
        par_en_d = par_en_q;
        par_d    = par_q;
        if (accept) begin
            par_en_d = par_en;
            // Even parity bit is the XOR of the byte; odd parity inverts it.
            par_d    = (^p_data) ^ par_typ;
        end
    end

    // Parity registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
        end else begin
            par_en_q <= par_en_d;
            par_q    <= par_d;
        end
    end

    assign par_bit = par_d;
`else
    // Parity inputs have no function in this build.
    logic unused_par_inputs;
    assign unused_par_inputs = par_en ^ par_typ;
    assign par_bit           = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every non-idle state lasts whole bit-times.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (data_valid) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_done && (idx_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = par_en_q ? StParity : StStop;
`else
                    state_d = StStop;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_done) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (bit_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Bit timing and data capture: counter restarts on every bit boundary or state change.
    always_comb begin
        cnt_d  = cnt_q + 8'd1;
        idx_d  = idx_q;
        data_d = data_q;

        if (bit_done || (state_q == StIdle) || (state_d != state_q)) begin
            cnt_d = 8'd0;
        end

        if (state_q == StIdle) begin
            idx_d = 3'd0;
        end else if ((state_q == StData) && bit_done) begin
            // Wraps to 0 after bit 7, which leaves it clean for the next frame.
            idx_d = idx_q + 3'd1;
        end

        if (accept) begin
            data_d = p_data;
        end
    end

    // Output logic: decode the line level for the upcoming cycle so the outputs can be
    // registered and still change in the same cycle as the state.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != StIdle);
        case (state_d)
            StIdle:   tx_d = 1'b1;
            StStart:  tx_d = 1'b0;
            StData:   tx_d = data_d[idx_d];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = par_bit;
`endif
            StStop:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

`ifndef UART_TX_PARITY_EN
    // Keeps the no-parity build free of a dangling net.
    logic unused_par_bit;
    assign unused_par_bit = par_bit;
`endif

    // Datapath and output registers; reset forces the line high and clears everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= 8'd0;
            idx_q  <= 3'd0;
            data_q <= 8'd0;
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            data_q <= data_d;
            tx_q   <= tx_d;
            busy_q <= busy_d;
        end
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized and directed checks of uart_tx against a per-cycle frame model.
// The model lists the expected line level and busy flag for every cycle of a frame.
module tb_uart_tx;

    localparam int unsigned P = 4;

`ifdef UART_TX_PARITY_EN
    localparam bit ParOn = 1'b1;
`else
    localparam bit ParOn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic       tx_out;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic exp_tx[$];
    logic exp_busy[$];
    logic obs_tx[$];
    logic obs_busy[$];

    always #5 clk = ~clk;

    uart_tx #(.PRESCALE(P)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    function automatic void clear_expected();
        exp_tx.delete();
        exp_busy.delete();
    endfunction

    // Append one frame followed by one idle-high cycle.
    function automatic void append_frame(input logic [7:0] d, input bit pe, input bit pt);
        int ones;
        bit pb;
        ones = $countones(d);
        pb   = bit'(ones % 2) ^ pt;
        for (int k = 0; k < P; k++) begin exp_tx.push_back(1'b0); exp_busy.push_back(1'b1); end
        for (int b = 0; b < 8; b++)
            for (int k = 0; k < P; k++) begin exp_tx.push_back(d[b]); exp_busy.push_back(1'b1); end
        if (ParOn && pe)
            for (int k = 0; k < P; k++) begin exp_tx.push_back(pb); exp_busy.push_back(1'b1); end
        for (int k = 0; k < P; k++) begin exp_tx.push_back(1'b1); exp_busy.push_back(1'b1); end
        exp_tx.push_back(1'b1);
        exp_busy.push_back(1'b0);
    endfunction

    function automatic void append_idle(input int n);
        for (int k = 0; k < n; k++) begin exp_tx.push_back(1'b1); exp_busy.push_back(1'b0); end
    endfunction

    // Record n cycles of outputs, sampled at the falling edge.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            obs_tx.push_back(tx_out);
            obs_busy.push_back(busy);
            @(negedge clk);
        end
    endtask

    // Present a one-cycle request from an idle falling edge.
    task automatic launch(input logic [7:0] d, input bit pe, input bit pt);
        obs_tx.delete();
        obs_busy.delete();
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        data_valid = 1'b0;
        p_data     = 8'h00;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (tx_out !== 1'b1 || busy !== 1'b0)
                $display("FAIL reset_hold cycle %0d: tx_out=%b busy=%b, required 1/0", c, tx_out, busy);
            else n_pass++;
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (tx_out !== 1'b1 || busy !== 1'b0)
                $display("FAIL reset_release cycle %0d: tx_out=%b busy=%b, required 1/0", c, tx_out, busy);
            else n_pass++;
        end
    endtask

    task automatic test_parity_modes();
        bit pe_tab[3] = '{1'b1, 1'b1, 1'b0};
        bit pt_tab[3] = '{1'b1, 1'b0, 1'b1};
        for (int t = 0; t < 3; t++) begin
            clear_expected();
            append_frame(8'b1000_1010, pe_tab[t], pt_tab[t]);
            launch(8'b1000_1010, pe_tab[t], pt_tab[t]);
            capture(exp_tx.size());
            for (int i = 0; i < exp_tx.size(); i++) begin
                n_checks++;
                if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i])
                    $display("FAIL parity_mode%0d cycle %0d: tx_out=%b busy=%b, required %b/%b",
                             t, i, obs_tx[i], obs_busy[i], exp_tx[i], exp_busy[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            logic [7:0] d;
            bit pe;
            bit pt;
            d  = 8'($urandom());
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            clear_expected();
            append_frame(d, pe, pt);
            launch(d, pe, pt);
            capture(exp_tx.size());
            for (int i = 0; i < exp_tx.size(); i++) begin
                n_checks++;
                if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i])
                    $display("FAIL random%0d (d=%h pe=%0d pt=%0d) cycle %0d: tx_out=%b busy=%b, required %b/%b",
                             f, d, pe, pt, i, obs_tx[i], obs_busy[i], exp_tx[i], exp_busy[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] d;
        bit pt;
        int rest;
        d  = 8'($urandom());
        pt = 1'($urandom_range(0, 1));
        clear_expected();
        append_frame(d, 1'b1, pt);
        rest = exp_tx.size() - (2 * P + 2);
        append_idle(3 * P);
        launch(d, 1'b1, pt);
        capture(2 * P + 1);
        p_data     = 8'hFF;
        par_en     = 1'b0;
        par_typ    = ~pt;
        data_valid = 1'b1;
        capture(1);
        data_valid = 1'b0;
        capture(rest + 3 * P);
        for (int i = 0; i < exp_tx.size(); i++) begin
            n_checks++;
            if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i])
                $display("FAIL busy_ignore cycle %0d: tx_out=%b busy=%b, required %b/%b",
                         i, obs_tx[i], obs_busy[i], exp_tx[i], exp_busy[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        clear_expected();
        append_frame(8'h55, 1'b0, 1'b0);
        append_frame(8'hA3, 1'b0, 1'b0);
        obs_tx.delete();
        obs_busy.delete();
        p_data     = 8'h55;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        data_valid = 1'b1;
        @(negedge clk);
        p_data = 8'hA3;
        capture(10 * P + 1);
        data_valid = 1'b0;
        capture(10 * P + 1);
        for (int i = 0; i < exp_tx.size(); i++) begin
            n_checks++;
            if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i])
                $display("FAIL back_to_back cycle %0d: tx_out=%b busy=%b, required %b/%b",
                         i, obs_tx[i], obs_busy[i], exp_tx[i], exp_busy[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'($urandom());
        clear_expected();
        append_frame(d, 1'b1, 1'b0);
        launch(d, 1'b1, 1'b0);
        // Stop inside data bit 3.
        capture(4 * P + 1);
        for (int i = 0; i < obs_tx.size(); i++) begin
            n_checks++;
            if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i])
                $display("FAIL mid_reset_prefix cycle %0d: tx_out=%b busy=%b, required %b/%b",
                         i, obs_tx[i], obs_busy[i], exp_tx[i], exp_busy[i]);
            else n_pass++;
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0)
            $display("FAIL mid_reset_abort: tx_out=%b busy=%b, required 1/0", tx_out, busy);
        else n_pass++;
        rst = 1'b1;
        for (int c = 0; c < 2 * P; c++) begin
            @(negedge clk);
            n_checks++;
            if (tx_out !== 1'b1 || busy !== 1'b0)
                $display("FAIL mid_reset_quiet cycle %0d: tx_out=%b busy=%b, required 1/0", c, tx_out, busy);
            else n_pass++;
        end
        d = 8'($urandom());
        clear_expected();
        append_frame(d, 1'b1, 1'b1);
        launch(d, 1'b1, 1'b1);
        capture(exp_tx.size());
        for (int i = 0; i < exp_tx.size(); i++) begin
            n_checks++;
            if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i])
                $display("FAIL mid_reset_recover cycle %0d: tx_out=%b busy=%b, required %b/%b",
                         i, obs_tx[i], obs_busy[i], exp_tx[i], exp_busy[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_parity_modes();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
